sort_11_frame_gather: RTL and testbench

Upstream feeder for the 11-input sorting network. It accepts a serial stream of 32-bit words over a valid/ready handshake and packs up to 11 words into one frame. Slots left empty by a short frame are padded with the maximum value so the pads sort to the top. The completed frame is held in registers and presented in parallel, with a frame-level handshake, to the combinational sorter's `data_0..data_10` inputs.

---
 rtl/sort_11_frame_gather_pkg.sv | 15 +
 rtl/sort_11_frame_gather.sv | 138 +++++++++++++
 tb/tb_sort_11_frame_gather.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_11_frame_gather_pkg.sv
// Shared types and constants for the 11-input sorter datapath.
package sort_pkg;

  typedef logic [31:0] data_t;

  localparam int SORT_N = 11;
  localparam data_t SORT_PAD = '1;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    DROP
  } gather_state_t;

endpackage

// File: rtl/sort_11_frame_gather.sv
// Serial-to-parallel frame gatherer feeding the 11-input sorting network.
// Packs up to 11 stream words into one frame, pads the unused slots with
// all-ones so they sort to the top, and holds the frame until taken.
module sort_11_frame_gather
  import sort_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  data_t       in_data,
  input  logic        in_last,
  output logic        frame_valid,
  input  logic        frame_ready,
  output data_t       frame_data_0,
  output data_t       frame_data_1,
  output data_t       frame_data_2,
  output data_t       frame_data_3,
  output data_t       frame_data_4,
  output data_t       frame_data_5,
  output data_t       frame_data_6,
  output data_t       frame_data_7,
  output data_t       frame_data_8,
  output data_t       frame_data_9,
  output data_t       frame_data_10,
  output logic [3:0]  frame_count,
  output logic        frame_err
);

  localparam logic [3:0] LAST_IDX = 4'(SORT_N - 1);

  gather_state_t state;
  logic [3:0]    idx;
  data_t         slot [SORT_N];

  logic              accept;
  logic              closing;
  logic [SORT_N-1:0] wr_data;
  logic [SORT_N-1:0] wr_pad;

  // Ready is a pure state decode so it reads 1 throughout reset.
  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;
  assign closing  = (state == FILL) && accept && (in_last || (idx == LAST_IDX));

  // Per-slot write enables: the addressed slot takes the word, and on a
  // closing beat every slot above it is padded.
  always_comb begin
    wr_data = '0;
    wr_pad  = '0;
    for (int unsigned i = 0; i < SORT_N; i++) begin
      if ((state == FILL) && accept) begin
        wr_data[i] = (4'(i) == idx);
        wr_pad[i]  = closing && (4'(i) > idx);
      end
    end
  end

  // Slot registers; frozen outside FILL so the held frame is stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SORT_N; i++) begin
        slot[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SORT_N; i++) begin
        if (wr_data[i]) begin
          slot[i] <= in_data;
        end else if (wr_pad[i]) begin
          slot[i] <= SORT_PAD;
        end
      end
    end
  end

  // Frame control FSM with registered frame-level outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      idx         <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      frame_err   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (closing) begin
              // idx is cleared here rather than on the take; it is unused
              // until the next frame starts, so the result is the same.
              state       <= HOLD;
              idx         <= '0;
              frame_valid <= 1'b1;
              frame_count <= idx + 4'd1;
              frame_err   <= (idx == LAST_IDX) && !in_last;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        HOLD: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            if (frame_err) begin
              state     <= DROP;
              frame_err <= 1'b0;
            end else begin
              state <= FILL;
            end
          end
        end
        DROP: begin
          if (accept && in_last) begin
            state <= FILL;
            idx   <= '0;
          end
        end
        default: begin
          state <= FILL;
          idx   <= '0;
        end
      endcase
    end
  end

  assign frame_data_0  = slot[0];
  assign frame_data_1  = slot[1];
  assign frame_data_2  = slot[2];
  assign frame_data_3  = slot[3];
  assign frame_data_4  = slot[4];
  assign frame_data_5  = slot[5];
  assign frame_data_6  = slot[6];
  assign frame_data_7  = slot[7];
  assign frame_data_8  = slot[8];
  assign frame_data_9  = slot[9];
  assign frame_data_10 = slot[10];

endmodule

// File: tb/tb_sort_11_frame_gather.sv
// Self-checking bench for sort_11_frame_gather: directed scenarios with
// literal expectations plus a randomized phase against a queue-based model.
module tb_sort_11_frame_gather;
  import sort_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  data_t       in_data;
  logic        in_last;
  logic        frame_valid;
  logic        frame_ready;
  data_t       dout [11];
  logic [3:0]  frame_count;
  logic        frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  sort_11_frame_gather dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .frame_data_0  (dout[0]),
    .frame_data_1  (dout[1]),
    .frame_data_2  (dout[2]),
    .frame_data_3  (dout[3]),
    .frame_data_4  (dout[4]),
    .frame_data_5  (dout[5]),
    .frame_data_6  (dout[6]),
    .frame_data_7  (dout[7]),
    .frame_data_8  (dout[8]),
    .frame_data_9  (dout[9]),
    .frame_data_10 (dout[10]),
    .frame_count   (frame_count),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words for the frame being collected and a
  // snapshot of the expected held frame.
  bit    m_hold;
  bit    m_drop;
  bit    m_err;
  int    m_cnt;
  data_t m_frame [11];
  data_t m_cur [$];

  // Model update on each clock edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0;
      m_drop = 0;
      m_err  = 0;
      m_cur.delete();
    end else if (m_hold) begin
      if (frame_ready) begin
        m_hold = 0;
        if (m_err) m_drop = 1;
        m_err = 0;
      end
    end else if (in_valid) begin
      if (m_drop) begin
        if (in_last) m_drop = 0;
      end else begin
        m_cur.push_back(in_data);
        if (in_last || m_cur.size() == 11) begin
          for (int i = 0; i < 11; i++)
            m_frame[i] = (i < m_cur.size()) ? m_cur[i] : 32'hFFFF_FFFF;
          m_cnt  = m_cur.size();
          m_err  = !in_last;
          m_hold = 1;
          m_cur.delete();
        end
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(!m_hold));
      check("frame_valid", 32'(frame_valid), 32'(m_hold));
      check("frame_err", 32'(frame_err), 32'(m_hold ? m_err : 1'b0));
      if (m_hold) begin
        check("frame_count", 32'(frame_count), 32'(m_cnt));
        for (int i = 0; i < 11; i++)
          check($sformatf("slot%0d", i), dout[i], m_frame[i]);
      end
    end
  end

  // Present one beat starting just after a rising edge; hold it until accepted.
  task automatic send(input data_t d, input logic last);
    bit acc;
    acc = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no accept expected accept for %h", d);
    end
  endtask

  // Pulse frame_ready for one edge; called at a falling edge.
  task automatic take_frame();
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    frame_ready = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_slot0", dout[0], 32'd0);
    check("rst_slot10", dout[10], 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full frame 1..11 with the consumer always ready
    frame_ready = 1'b1;
    for (int i = 1; i <= 11; i++) send(data_t'(i), i == 11);
    @(negedge clk);
    check("full_valid", 32'(frame_valid), 32'd1);
    check("full_count", 32'(frame_count), 32'd11);
    check("full_err", 32'(frame_err), 32'd0);
    for (int i = 0; i < 11; i++) check($sformatf("full_slot%0d", i), dout[i], 32'(i + 1));
    @(posedge clk);
    #1;
    frame_ready = 1'b0;

    // Short frame under 5 cycles of backpressure
    send(32'd7, 1'b0);
    send(32'd3, 1'b0);
    send(32'd9, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(frame_valid), 32'd1);
      check("bp_count", 32'(frame_count), 32'd3);
      check("bp_slot0", dout[0], 32'd7);
      check("bp_slot1", dout[1], 32'd3);
      check("bp_slot2", dout[2], 32'd9);
      check("bp_slot3", dout[3], 32'hFFFF_FFFF);
      check("bp_slot10", dout[10], 32'hFFFF_FFFF);
    end
    take_frame();
    @(negedge clk);
    check("bp_after_ready", 32'(in_ready), 32'd1);
    check("bp_after_valid", 32'(frame_valid), 32'd0);

    // Overflow: 14 beats, tail discarded, then a fresh one-word frame
    for (int i = 1; i <= 11; i++) send(data_t'(100 + i), 1'b0);
    @(negedge clk);
    check("ovf_err", 32'(frame_err), 32'd1);
    check("ovf_count", 32'(frame_count), 32'd11);
    check("ovf_slot10", dout[10], 32'd111);
    take_frame();
    @(negedge clk);
    check("ovf_err_clear", 32'(frame_err), 32'd0);
    check("ovf_drop_ready", 32'(in_ready), 32'd1);
    send(32'd112, 1'b0);
    send(32'd113, 1'b0);
    send(32'd114, 1'b1);
    @(negedge clk);
    check("ovf_drop_valid", 32'(frame_valid), 32'd0);
    send(32'hAA, 1'b1);
    @(negedge clk);
    check("ovf_next_slot0", dout[0], 32'hAA);
    check("ovf_next_err", 32'(frame_err), 32'd0);
    check("ovf_next_count", 32'(frame_count), 32'd1);
    check("ovf_next_slot1", dout[1], 32'hFFFF_FFFF);
    take_frame();

    // Reset in the middle of a frame
    for (int i = 0; i < 4; i++) send(data_t'(50 + i), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(frame_valid), 32'd0);
    check("mid_rst_count", 32'(frame_count), 32'd0);
    check("mid_rst_slot0", dout[0], 32'd0);
    check("mid_rst_slot3", dout[3], 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'd5, 1'b0);
    send(32'd6, 1'b1);
    @(negedge clk);
    check("post_rst_count", 32'(frame_count), 32'd2);
    check("post_rst_slot0", dout[0], 32'd5);
    check("post_rst_slot1", dout[1], 32'd6);
    check("post_rst_slot2", dout[2], 32'hFFFF_FFFF);
    take_frame();

    // Single-word frame of value 0
    send(32'd0, 1'b1);
    @(negedge clk);
    check("single_count", 32'(frame_count), 32'd1);
    check("single_slot0", dout[0], 32'd0);
    check("single_slot1", dout[1], 32'hFFFF_FFFF);
    check("single_slot10", dout[10], 32'hFFFF_FFFF);
    take_frame();

    // Randomized traffic on both handshakes
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      in_valid    = ($urandom_range(0, 9) < 7);
      in_data     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      in_last     = ($urandom_range(0, 8) == 0);
      frame_ready = ($urandom_range(0, 9) < 6);
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    frame_ready = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
